// File: rtl/vga_sync_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_tracker
//  Purpose  : Receive-side VGA sync tracker. Samples an incoming hsync/vsync
//             pair, measures the line period and the hsync high time, locks
//             once the line period has been stable for LOCK_LINES lines, and
//             then regenerates pixel/line counters aligned to the input.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CNT_W       width of all counters and measurement outputs
//    LOCK_LINES  consecutive matching line periods needed to lock (1..15)
//    TOL         allowed |period - stored period| in clocks
//  Ports
//    clk         pixel clock (single domain)
//    reset       synchronous active-high reset
//    horzSyncIn  horizontal sync, active-high pulse
//    vertSyncIn  vertical sync, active-high pulse
//    locked      high while tracking a stable line period
//    lineStart   1-cycle pulse per accepted hsync rising edge while locked
//    frameStart  1-cycle pulse per vsync rising edge while locked
//    pixelX      clocks since last hsync rising edge (0 when unlocked)
//    lineY       lines since last vsync rising edge (0 when unlocked)
//    lineLen     last stored line period, in clocks
//    pulseWidth  last measured hsync high time, in clocks
//  Build option
//    VGA_SYNC_2FF_EN  adds a two-flop synchronizer on each sync input
//                     (all latencies grow by 2 cycles)
// ============================================================================
module vga_sync_tracker #(
  parameter int CNT_W      = 12,
  parameter int LOCK_LINES = 4,
  parameter int TOL        = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             horzSyncIn,
  input  logic             vertSyncIn,
  output logic             locked,
  output logic             lineStart,
  output logic             frameStart,
  output logic [CNT_W-1:0] pixelX,
  output logic [CNT_W-1:0] lineY,
  output logic [CNT_W-1:0] lineLen,
  output logic [CNT_W-1:0] pulseWidth
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   TOL_EXT  = (CNT_W+1)'(TOL);
  localparam logic [3:0]       LOCK_CNT = 4'(LOCK_LINES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Optional input synchronizer
  // --------------------------------------------------------------------------
  logic hs_in;
  logic vs_in;

`ifdef VGA_SYNC_2FF_EN
  logic [1:0] hs_sync_q;
  logic [1:0] vs_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_sync_q <= 2'b00;
      vs_sync_q <= 2'b00;
    end else begin
      hs_sync_q <= {hs_sync_q[0], horzSyncIn};
      vs_sync_q <= {vs_sync_q[0], vertSyncIn};
    end
  end

  assign hs_in = hs_sync_q[1];
  assign vs_in = vs_sync_q[1];
`else
  assign hs_in = horzSyncIn;
  assign vs_in = vertSyncIn;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           state_q,       state_d;
  logic             hs_q,          hs_q2;
  logic             vs_q,          vs_q2;
  logic [CNT_W-1:0] run_cnt_q,     run_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q,      hi_cnt_d;
  logic [3:0]       match_cnt_q,   match_cnt_d;
  logic [1:0]       miss_cnt_q,    miss_cnt_d;
  logic [CNT_W-1:0] line_len_q,    line_len_d;
  logic [CNT_W-1:0] pulse_width_q, pulse_width_d;
  logic [CNT_W-1:0] pixel_x_q,     pixel_x_d;
  logic [CNT_W-1:0] line_y_q,      line_y_d;
  logic             line_start_q,  line_start_d;
  logic             frame_start_q, frame_start_d;

  // --------------------------------------------------------------------------
  // Edge detection and period measurement
  // --------------------------------------------------------------------------
  logic             hs_rise;
  logic             hs_fall;
  logic             vs_rise;
  logic [CNT_W:0]   period;
  logic [CNT_W:0]   len_ext;
  logic [CNT_W:0]   diff;
  logic             in_tol;
  logic             timeout;
  logic [CNT_W-1:0] period_sat;
  logic             was_locked;
  logic             now_locked;

  assign hs_rise = hs_q & ~hs_q2;
  assign hs_fall = ~hs_q & hs_q2;
  assign vs_rise = vs_q & ~vs_q2;

  // One extra bit keeps P = runCnt + 1 and |P - lineLen| from wrapping.
  assign period     = {1'b0, run_cnt_q} + (CNT_W+1)'(1);
  assign len_ext    = {1'b0, line_len_q};
  assign diff       = (period >= len_ext) ? (period - len_ext) : (len_ext - period);
  assign in_tol     = (diff <= TOL_EXT);
  assign period_sat = period[CNT_W] ? CNT_MAX : period[CNT_W-1:0];

  // Loss of signal: no hsync edge for a full counter span. An edge arriving
  // on the saturation cycle is still processed normally.
  assign timeout = (run_cnt_q == CNT_MAX) & ~hs_rise;

  // --------------------------------------------------------------------------
  // Lock state machine
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    line_len_d  = line_len_q;

    case (state_q)
      ST_SEARCH: begin
        if (hs_rise) begin
          state_d     = ST_MEASURE;
          match_cnt_d = 4'd0;
          miss_cnt_d  = 2'd0;
        end
      end
      ST_MEASURE: begin
        if (hs_rise) begin
          if (in_tol) begin
            match_cnt_d = match_cnt_q + 4'd1;
            if ((match_cnt_q + 4'd1) == LOCK_CNT) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = 2'd0;
            end
          end else begin
            line_len_d  = period_sat;
            match_cnt_d = 4'd0;
          end
        end
      end
      ST_LOCKED: begin
        if (hs_rise) begin
          if (in_tol) begin
            miss_cnt_d = 2'd0;
          end else if (miss_cnt_q != 2'd0) begin
            state_d     = ST_SEARCH;
            match_cnt_d = 4'd0;
            miss_cnt_d  = 2'd0;
          end else begin
            miss_cnt_d = miss_cnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d     = ST_SEARCH;
        match_cnt_d = 4'd0;
        miss_cnt_d  = 2'd0;
      end
    endcase

    if (timeout) begin
      state_d     = ST_SEARCH;
      match_cnt_d = 4'd0;
      miss_cnt_d  = 2'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Counters and registered outputs
  // --------------------------------------------------------------------------
  assign was_locked = (state_q == ST_LOCKED);
  assign now_locked = (state_d == ST_LOCKED);

  always_comb begin
    run_cnt_d     = run_cnt_q;
    hi_cnt_d      = hi_cnt_q;
    pulse_width_d = pulse_width_q;
    line_y_d      = line_y_q;

    if (hs_rise) begin
      run_cnt_d = '0;
    end else if (run_cnt_q != CNT_MAX) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end

    if (hs_fall) begin
      pulse_width_d = hi_cnt_q;
      hi_cnt_d      = '0;
    end else if (hs_q && (hi_cnt_q != CNT_MAX)) begin
      hi_cnt_d = hi_cnt_q + 1'b1;
    end

    // Pulses only fire if the state was and stays LOCKED, so the edge that
    // drops lock produces no lineStart.
    line_start_d  = hs_rise & was_locked & now_locked;
    frame_start_d = vs_rise & was_locked & now_locked;

    pixel_x_d = now_locked ? run_cnt_d : '0;

    if (!now_locked) begin
      line_y_d = '0;
    end else if (vs_rise) begin
      line_y_d = '0;
    end else if (line_start_d && (line_y_q != CNT_MAX)) begin
      line_y_d = line_y_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_SEARCH;
      hs_q          <= 1'b0;
      hs_q2         <= 1'b0;
      vs_q          <= 1'b0;
      vs_q2         <= 1'b0;
      run_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      match_cnt_q   <= 4'd0;
      miss_cnt_q    <= 2'd0;
      line_len_q    <= '0;
      pulse_width_q <= '0;
      pixel_x_q     <= '0;
      line_y_q      <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_in;
      hs_q2         <= hs_q;
      vs_q          <= vs_in;
      vs_q2         <= vs_q;
      run_cnt_q     <= run_cnt_d;
      hi_cnt_q      <= hi_cnt_d;
      match_cnt_q   <= match_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      line_len_q    <= line_len_d;
      pulse_width_q <= pulse_width_d;
      pixel_x_q     <= pixel_x_d;
      line_y_q      <= line_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign locked     = was_locked;
  assign lineStart  = line_start_q;
  assign frameStart = frame_start_q;
  assign pixelX     = pixel_x_q;
  assign lineY      = line_y_q;
  assign lineLen    = line_len_q;
  assign pulseWidth = pulse_width_q;

endmodule
`default_nettype wire

// File: doc/vga_sync_tracker.md
# vga_sync_tracker

Receive-side counterpart of the VGA sync generators. It samples an incoming horizontal and vertical sync pair and measures the line period and the horizontal pulse width. It locks once the line period has been stable for a set number of lines, then regenerates pixel and line counters aligned to the incoming timing. It sits at the video input of the Simon Says display path and provides `locked`, `pixelX` and `lineY` to downstream overlay and checking logic.

## Interface
- `CNT_W`, 12, width of all counters and measurement outputs.
- `LOCK_LINES`, 4, consecutive matching line periods required to lock (1..15).
- `TOL`, 2, allowed absolute deviation in clocks between successive line periods.
- `clk`  in  1  pixel clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `horzSyncIn`  in  1  horizontal sync, active-high pulse.
- `vertSyncIn`  in  1  vertical sync, active-high pulse.
- `locked`  out  1  high while tracking a stable line period.
- `lineStart`  out  1  one-cycle pulse on each accepted `horzSyncIn` rising edge while locked.
- `frameStart`  out  1  one-cycle pulse on each `vertSyncIn` rising edge while locked.
- `pixelX`  out  CNT_W  clocks since the last `horzSyncIn` rising edge while locked; 0 otherwise.
- `lineY`  out  CNT_W  lines since the last `vertSyncIn` rising edge while locked; 0 otherwise.
- `lineLen`  out  CNT_W  last stored line period, in clocks.
- `pulseWidth`  out  CNT_W  last measured `horzSyncIn` high time, in clocks.

## Operation
- Each input is registered once (`hs_q`, `vs_q`) and then delayed once more. A rising edge is `hs_q & ~hs_q2`; a falling edge is `~hs_q & hs_q2`. `vs` uses the same detection.
- `runCnt`:
  - Cleared to 0 on an `hs` rising edge; otherwise increments by 1.
  - Saturates at 2^CNT_W−1.
  - Measured period `P = runCnt + 1`, taken on the edge cycle.
- `hiCnt`:
  - Counts cycles while `hs_q` is 1.
  - On a falling edge, `pulseWidth <= hiCnt` and `hiCnt` clears.
  - A 41-clock pulse yields 41.
- State machine:
  - SEARCH:
    - `locked=0`.
    - First `hs` rising edge → MEASURE; `matchCnt=0`.
  - MEASURE, on each `hs` rising edge:
    - If `|P − lineLen| <= TOL`: `matchCnt++`.
    - Otherwise: `lineLen <= P` and `matchCnt <= 0`.
    - When `matchCnt` reaches LOCK_LINES → LOCKED.
  - LOCKED, on each `hs` rising edge:
    - Match: `missCnt <= 0`, and `lineLen` is not updated.
    - Mismatch: `missCnt++`. A second consecutive mismatch → SEARCH with `matchCnt=0` and `missCnt=0`.
  - Any state: `runCnt` reaching saturation forces SEARCH. This is the loss-of-signal timeout.
- `lineY`:
  - Increments on each `hs` rising edge while locked.
  - Clears on a `vs` rising edge.
  - If both edges occur in the same cycle, `lineY <= 0` (vsync wins), and `lineStart` and `frameStart` both pulse.
  - `lineY` saturates and does not wrap.
- Difference arithmetic uses CNT_W+1 bits so `|P − lineLen|` cannot wrap.

## Timing
- Reset values: state SEARCH, all outputs 0, all internal counters 0.
- Reset asserted mid-line or while locked takes effect on the next clock edge. No partial measurement survives reset.
- Latency: input rising edge at cycle n → edge detected at n+2. `lineStart`/`frameStart` are registered and high at n+3.
- `locked` rises in the cycle after the edge that completes LOCK_LINES matches. It falls in the cycle after the second consecutive mismatch or after the timeout.
- `pixelX` equals `runCnt` registered, so it reads 0 in the cycle `lineStart` is high.
- A lost lock takes effect immediately: the current line's `lineStart` is suppressed, and `pixelX` and `lineY` go to 0 in the same cycle `locked` falls.

## Configuration
- `VGA_SYNC_2FF_EN`:
  - When defined, each input passes through two extra synchronizer flops ahead of the edge detector, for asynchronous sync sources.
  - All latencies above grow by 2 cycles: pulse at n+5.
  - When undefined, the inputs are taken as already synchronous to `clk`, with latencies as stated.

## Test plan
- Lock acquisition:
  - Stimulus: `horzSyncIn` period 800, high for 41 clocks, TOL=2, LOCK_LINES=4.
  - Required response: `locked` rises after the 6th rising edge; `lineLen=800`; `pulseWidth=41`; `lineStart` every 800 cycles; `pixelX` runs 0..799.
- Tolerance:
  - Stimulus: once locked, periods of 798, 802, 801.
  - Required response: stays locked and `lineLen` stays 800.
  - Stimulus: a single 810-clock line.
  - Required response: stays locked. A further 810 causes `locked` to fall.
- Frame handling:
  - Stimulus: `vertSyncIn` rising edge coincident with an `hs` rising edge while locked.
  - Required response: `frameStart` and `lineStart` pulse together; `lineY=0`; `lineY=1` after the next line.
- Timeout:
  - Stimulus: hold `horzSyncIn` low for 4096 clocks while locked.
  - Required response: state returns to SEARCH; `locked=0`; `pixelX=0`.
- Reset mid-operation:
  - Stimulus: assert `reset` for 1 cycle while locked at `pixelX=300`.
  - Required response: the next cycle shows all outputs 0, and re-lock takes the full 6 edges.
- Macro:
  - Stimulus: rerun the first scenario with `VGA_SYNC_2FF_EN` defined.
  - Required response: every `lineStart` is delayed by exactly 2 cycles.
